// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer/status controller for an asynchronous FIFO: binary and Gray
// write pointers, RAM write address and registered full flag.
// Define WPTR_FULL_STATUS_EN to add fill level, almost-full and sticky overflow.
module wptr_full_ctrl #(
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned AF_MARGIN = 2
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 winc,
    input  logic [ADDR_SIZE:0]   wq2_rptr,
    input  logic                 wovf_clr,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [ADDR_SIZE:0]   wptr,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [ADDR_SIZE:0]   wlevel,
    output logic                 woverflow
);

    localparam int unsigned PW        = ADDR_SIZE + 1;
    localparam int unsigned DEPTH     = 1 << ADDR_SIZE;
    localparam int unsigned AF_THRESH = DEPTH - AF_MARGIN;

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next_c;
    logic [PW-1:0] wgray_next_c;
    logic [PW-1:0] rptr_full_c;
    logic          winc_ok_c;
    logic          wfull_next_c;

    // Next pointer values; full compares against the read pointer with its top two bits inverted.
    always_comb begin
        winc_ok_c    = winc & ~wfull;
        wbin_next_c  = wbin + PW'(winc_ok_c);
        wgray_next_c = (wbin_next_c >> 1) ^ wbin_next_c;
        rptr_full_c  = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
        wfull_next_c = (wgray_next_c == rptr_full_c);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin  <= '0;
            wptr  <= '0;
            wfull <= 1'b0;
        end else begin
            wbin  <= wbin_next_c;
            wptr  <= wgray_next_c;
            wfull <= wfull_next_c;
        end
    end

    assign waddr = wbin[ADDR_SIZE-1:0];

`ifdef WPTR_FULL_STATUS_EN
    logic [PW-1:0] rbin_c;
    logic [PW-1:0] wlevel_next_c;
    logic          walmost_full_next_c;
    logic          woverflow_next_c;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin_c = '0;
        for (int i = 0; i < int'(PW); i++) begin
            rbin_c[i] = ^(wq2_rptr >> i);
        end
        wlevel_next_c       = wbin_next_c - rbin_c;
        walmost_full_next_c = (wlevel_next_c >= PW'(AF_THRESH));
        woverflow_next_c    = woverflow;
        if (winc && wfull) begin
            woverflow_next_c = 1'b1;
        end else if (wovf_clr) begin
            woverflow_next_c = 1'b0;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
            woverflow    <= 1'b0;
        end else begin
            wlevel       <= wlevel_next_c;
            walmost_full <= walmost_full_next_c;
            woverflow    <= woverflow_next_c;
        end
    end
`else
    logic unused_wovf_clr_c;

    assign unused_wovf_clr_c = wovf_clr;
    assign wlevel            = '0;
    assign walmost_full      = 1'b0;
    assign woverflow         = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Scoreboard bench for wptr_full_ctrl (ADDR_SIZE=4, AF_MARGIN=2); status expectations
// follow whether WPTR_FULL_STATUS_EN is defined.
module tb_wptr_full_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned PW = AW + 1;

    logic          wclk = 1'b0;
    logic          wrst_n;
    logic          winc;
    logic [PW-1:0] wq2_rptr;
    logic          wovf_clr;
    logic [AW-1:0] waddr;
    logic [PW-1:0] wptr;
    logic          wfull;
    logic          walmost_full;
    logic [PW-1:0] wlevel;
    logic          woverflow;

    typedef struct {
        logic [AW-1:0] waddr;
        logic [PW-1:0] wptr;
        logic          wfull;
        logic          af;
        logic [PW-1:0] lvl;
        logic          ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    int   m_w   = 0;
    int   m_rb  = 0;
    logic m_full = 1'b0;
    logic m_ovf  = 1'b0;

    wptr_full_ctrl #(.ADDR_SIZE(AW), .AF_MARGIN(2)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wovf_clr     (wovf_clr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    always #5 wclk = ~wclk;

    function automatic logic [PW-1:0] to_gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b);
        return (v >> 1) ^ v;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".waddr"}, 32'(waddr), 32'd0);
        check_val({tag, ".wptr"}, 32'(wptr), 32'd0);
        check_val({tag, ".wfull"}, 32'(wfull), 32'd0);
        check_val({tag, ".walmost_full"}, 32'(walmost_full), 32'd0);
        check_val({tag, ".wlevel"}, 32'(wlevel), 32'd0);
        check_val({tag, ".woverflow"}, 32'(woverflow), 32'd0);
    endtask

    task automatic model_reset();
        m_w    = 0;
        m_rb   = 0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        exp_q.delete();
    endtask

    // One clock: drive inputs, push the model's prediction, compare after the edge.
    task automatic step(input logic inc, input logic clr);
        exp_t e;
        int   lvl;
        logic full_prev;
        @(negedge wclk);
        winc     = inc;
        wovf_clr = clr;
        wq2_rptr = to_gray(m_rb);
        full_prev = m_full;
        if (inc && !m_full) m_w = (m_w + 1) % 32;
        lvl    = (m_w - m_rb + 32) % 32;
        m_full = (lvl == 16);
        if (inc && full_prev) m_ovf = 1'b1;
        else if (clr)         m_ovf = 1'b0;
        e.waddr = AW'(m_w);
        e.wptr  = to_gray(m_w);
        e.wfull = m_full;
`ifdef WPTR_FULL_STATUS_EN
        e.lvl = PW'(lvl);
        e.af  = (lvl >= 14);
        e.ovf = m_ovf;
`else
        e.lvl = '0;
        e.af  = 1'b0;
        e.ovf = 1'b0;
`endif
        exp_q.push_back(e);
        @(posedge wclk);
        #1;
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_val("waddr", 32'(waddr), 32'(e.waddr));
            check_val("wptr", 32'(wptr), 32'(e.wptr));
            check_val("wfull", 32'(wfull), 32'(e.wfull));
            check_val("walmost_full", 32'(walmost_full), 32'(e.af));
            check_val("wlevel", 32'(wlevel), 32'(e.lvl));
            check_val("woverflow", 32'(woverflow), 32'(e.ovf));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lvl;
        wrst_n   = 1'b0;
        winc     = 1'b0;
        wovf_clr = 1'b0;
        wq2_rptr = '0;
        #12;
        check_all_zero("reset");
        @(negedge wclk);
        wrst_n = 1'b1;

        // A short burst, then reset lands between clock edges
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        @(negedge wclk);
        winc = 1'b1;
        #2;
        wrst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        wq2_rptr = '0;
        winc     = 1'b0;
        @(negedge wclk);
        wrst_n = 1'b1;
        #1;
        check_val("first_waddr", 32'(waddr), 32'd0);
        check_val("first_wptr", 32'(wptr), 32'd0);

        // Fill from empty: 16 writes, then a rejected 17th
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
        check_val("full_wptr", 32'(wptr), 32'h18);
        step(1'b1, 1'b0);
        check_val("ovf_wptr_hold", 32'(wptr), 32'h18);

        // Overflow set beats clear; clear alone drops it
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // Drain release
        m_rb = 1;
        step(1'b0, 1'b0);
        m_rb = 2;
        step(1'b0, 1'b0);

        // Drain to level 3, then write and read together across the wrap
        while (m_rb < 13) begin
            m_rb++;
            step(1'b0, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            m_rb = (m_rb + 1) % 32;
            step(1'b1, 1'b0);
        end

        // Random traffic with occasional clears
        for (int i = 0; i < 200; i++) begin
            lvl = (m_w - m_rb + 32) % 32;
            if (lvl > 0 && $urandom_range(0, 2) == 0) m_rb = (m_rb + 1) % 32;
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
        end

        @(negedge wclk);
        winc     = 1'b0;
        wovf_clr = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
